// File: rtl/lcd_seq_pkg.sv
// lcd_bus_sequencer shared types and HD44780 constants.
// State encoding, init ROM and command classification.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    localparam logic [7:0] FUNC_SET_8BIT_2L = 8'h38;
    localparam logic [7:0] DISP_ON          = 8'h0C;
    localparam logic [7:0] CLEAR            = 8'h01;
    localparam logic [7:0] ENTRY_INC        = 8'h06;

    localparam logic [2:0] INIT_LEN = 3'd4;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FUNC_SET_8BIT_2L;
            2'd1:    b = DISP_ON;
            2'd2:    b = CLEAR;
            default: b = ENTRY_INC;
        endcase
        return b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs,
                                         input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_bus_sequencer_timer.sv
// lcd_delay_timer: single down-counter shared by all states.
// Loaded with N-1 on state entry; done while it reads zero.
module lcd_delay_timer #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: HD44780 bus timing and power-on init.
// Accepts instruction/data bytes over valid/ready.
module lcd_bus_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 4,
    parameter int SHORT_CYC = 2_500,
    parameter int LONG_CYC  = 100_000,
    parameter int INIT_CYC  = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    input  logic       backlight,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B = (HOLD_CYC > SHORT_CYC) ? HOLD_CYC : SHORT_CYC;
    localparam int MAX_C = (LONG_CYC > INIT_CYC) ? LONG_CYC : INIT_CYC;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int CW = $clog2(MAX_CYC) + 1;

    // A zero-length phase behaves as one cycle.
    localparam logic [CW-1:0] SETUP_LD =
        CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CW-1:0] EN_LD =
        CW'((EN_CYC > 0) ? EN_CYC - 1 : 0);
    localparam logic [CW-1:0] HOLD_LD =
        CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] SHORT_LD =
        CW'((SHORT_CYC > 0) ? SHORT_CYC - 1 : 0);
    localparam logic [CW-1:0] LONG_LD =
        CW'((LONG_CYC > 0) ? LONG_CYC - 1 : 0);
    localparam logic [CW-1:0] INIT_LD =
        CW'((INIT_CYC > 0) ? INIT_CYC - 1 : 0);

    state_t        state_q, state_d;
    logic [2:0]    idx_q;
    logic          step_load;
    logic [CW-1:0] step_val;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;
    logic          accept;
    logic          init_load;
    logic          finish_init;

    assign tmr_load = reset | step_load;
    assign tmr_val  = reset ? INIT_LD : step_val;

    lcd_delay_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign req_ready = (state_q == IDLE) && init_done;
    assign lcd_rw    = 1'b0 && (CLK_HZ > 0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, timer reloads and datapath strobes.
    always_comb begin
        state_d     = state_q;
        step_load   = 1'b0;
        step_val    = '0;
        accept      = 1'b0;
        init_load   = 1'b0;
        finish_init = 1'b0;
        unique case (state_q)
            INIT_WAIT: begin
                if (tmr_done) state_d = INIT_LOAD;
            end
            INIT_LOAD: begin
                init_load = 1'b1;
                state_d   = SETUP;
                step_load = 1'b1;
                step_val  = SETUP_LD;
            end
            IDLE: begin
                if (req_valid && init_done) begin
                    accept    = 1'b1;
                    state_d   = SETUP;
                    step_load = 1'b1;
                    step_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d   = PULSE;
                    step_load = 1'b1;
                    step_val  = EN_LD;
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_d   = HOLD;
                    step_load = 1'b1;
                    step_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d   = EXEC;
                    step_load = 1'b1;
                    step_val  = is_long_cmd(lcd_rs, lcd_data)
                              ? LONG_LD : SHORT_LD;
                end
            end
            EXEC: begin
                if (tmr_done) begin
                    if (init_done) begin
                        state_d = IDLE;
                    end else if (idx_q == INIT_LEN) begin
                        state_d     = IDLE;
                        finish_init = 1'b1;
                    end else begin
                        state_d = INIT_LOAD;
                    end
                end
            end
            default: state_d = INIT_WAIT;
        endcase
    end

    // Registered pin drivers, byte latch and init progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            lcd_on    <= 1'b0;
            lcd_blon  <= 1'b0;
            init_done <= 1'b0;
            idx_q     <= 3'd0;
        end else begin
            lcd_on   <= 1'b1;
            lcd_blon <= backlight & lcd_on;
            lcd_en   <= (state_d == PULSE);
            if (accept) begin
                lcd_rs   <= req_rs;
                lcd_data <= req_data;
            end else if (init_load) begin
                lcd_rs   <= 1'b0;
                lcd_data <= init_rom(idx_q[1:0]);
                idx_q    <= idx_q + 3'd1;
            end
            if (finish_init) init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with shortened delays.
// Table-driven writes plus init, back-to-back and reset sequences.
module tb_lcd_bus_sequencer;

    localparam int S = 2;
    localparam int E = 4;
    localparam int H = 2;
    localparam int SH = 10;
    localparam int LG = 40;
    localparam int IN = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       backlight;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_on;
    logic       lcd_blon;

    lcd_bus_sequencer #(
        .CLK_HZ    (50_000_000),
        .SETUP_CYC (S),
        .EN_CYC    (E),
        .HOLD_CYC  (H),
        .SHORT_CYC (SH),
        .LONG_CYC  (LG),
        .INIT_CYC  (IN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .backlight (backlight),
        .init_done (init_done),
        .lcd_data  (lcd_data),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int  rise_cnt = 0;
    bit  en_prev  = 1'b0;
    bit  rw_bad   = 1'b0;

    always @(negedge clk) begin
        if (lcd_en && !en_prev) rise_cnt = rise_cnt + 1;
        en_prev = lcd_en;
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    end

    typedef struct {
        logic [7:0] data;
        int         rise;
        int         fall;
    } pulse_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exec;
    } wr_t;

    pulse_t init_tbl[4];
    wr_t    wr_tbl[7];

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endfunction

    // Called at the negedge right after reset was released.
    task automatic init_seq(input string tag);
        int   r;
        bit   en_bad;
        bit   rdy_bad;
        bit   on_bad;
        logic exp_en;
        r = cyc;
        en_bad = 1'b0;
        rdy_bad = 1'b0;
        on_bad = 1'b0;
        for (int off = 1; off <= 206; off++) begin
            @(negedge clk);
            exp_en = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (off >= init_tbl[j].rise && off < init_tbl[j].fall)
                    exp_en = 1'b1;
                if (off == init_tbl[j].rise)
                    check($sformatf("%s_byte%0d", tag, j),
                          {lcd_rs, lcd_data},
                          {1'b0, init_tbl[j].data});
            end
            if (lcd_en !== exp_en) en_bad = 1'b1;
            if (lcd_on !== 1'b1) on_bad = 1'b1;
            if (off < 206 && req_ready !== 1'b0) rdy_bad = 1'b1;
            if (off == 1) check({tag, "_blon_off"}, lcd_blon, 0);
            if (off == 2) check({tag, "_blon_on"}, lcd_blon, 1);
            if (off == 205) check({tag, "_done_early"}, init_done, 0);
            if (off == 206) begin
                check({tag, "_done"}, init_done, 1);
                check({tag, "_ready"}, req_ready, 1);
            end
        end
        check({tag, "_en_timing"}, en_bad, 0);
        check({tag, "_lcd_on"}, on_bad, 0);
        check({tag, "_ready_low"}, rdy_bad, 0);
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (req_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({name, "_ready_wait"}, req_ready, 1);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d,
                            input int exec, input string name);
        int   k;
        int   t;
        bit   en_bad;
        bit   st_bad;
        logic exp_en;
        wait_ready(name);
        if (req_ready !== 1'b1) return;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(negedge clk);
        k = cyc;
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~d;
        en_bad = 1'b0;
        st_bad = 1'b0;
        t = 0;
        while (req_ready !== 1'b1 && t < 200) begin
            exp_en = (cyc >= k + S) && (cyc < k + S + E);
            if (lcd_en !== exp_en) en_bad = 1'b1;
            if (lcd_rs !== rs || lcd_data !== d) st_bad = 1'b1;
            @(negedge clk);
            t++;
        end
        check({name, "_en"}, en_bad, 0);
        check({name, "_stable"}, st_bad, 0);
        check({name, "_ready_at"}, cyc - k, S + E + H + exec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[3];
        int         idx;
        int         acc_prev;
        int         rc0;
        int         k;
        bit         ready_prev;

        init_tbl[0] = '{8'h38, 103, 107};
        init_tbl[1] = '{8'h0C, 122, 126};
        init_tbl[2] = '{8'h01, 141, 145};
        init_tbl[3] = '{8'h06, 190, 194};

        wr_tbl[0] = '{1'b1, 8'h41, SH};
        wr_tbl[1] = '{1'b0, 8'h02, LG};
        wr_tbl[2] = '{1'b1, 8'h02, SH};
        wr_tbl[3] = '{1'b0, 8'h01, LG};
        wr_tbl[4] = '{1'b0, 8'h03, LG};
        wr_tbl[5] = '{1'b0, 8'h04, SH};
        wr_tbl[6] = '{1'b0, 8'h80, SH};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        backlight = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_en", lcd_en, 0);
        check("rst_rs_data", {lcd_rs, lcd_data}, 0);
        check("rst_on_blon", {lcd_on, lcd_blon}, 0);
        check("rst_ready_done", {req_ready, init_done}, 0);
        reset = 1'b0;
        init_seq("init");

        for (int i = 0; i < 7; i++) begin
            do_write(wr_tbl[i].rs, wr_tbl[i].data, wr_tbl[i].exec,
                     $sformatf("wr%0d", i));
        end

        q[0] = 8'hA1;
        q[1] = 8'hB2;
        q[2] = 8'hC3;
        wait_ready("b2b");
        rc0 = rise_cnt;
        idx = 0;
        acc_prev = 0;
        req_rs = 1'b1;
        req_data = q[0];
        req_valid = 1'b1;
        ready_prev = req_ready;
        for (int t = 0; t < 200 && idx < 3; t++) begin
            @(negedge clk);
            if (ready_prev) begin
                check($sformatf("b2b_data%0d", idx),
                      {lcd_rs, lcd_data}, {1'b1, q[idx]});
                if (idx > 0)
                    check($sformatf("b2b_gap%0d", idx),
                          cyc - acc_prev, S + E + H + SH + 1);
                acc_prev = cyc;
                idx++;
                if (idx == 3) req_valid = 1'b0;
                else req_data = q[idx];
            end
            ready_prev = req_ready;
        end
        req_valid = 1'b0;
        check("b2b_count", idx, 3);
        repeat (30) @(negedge clk);
        check("b2b_pulses", rise_cnt - rc0, 3);
        check("b2b_idle", req_ready, 1);

        backlight = 1'b0;
        @(negedge clk);
        check("bl_off", lcd_blon, 0);
        backlight = 1'b1;
        #1;
        check("bl_not_comb", lcd_blon, 0);
        @(negedge clk);
        check("bl_on", lcd_blon, 1);
        backlight = 1'b0;
        @(negedge clk);
        check("bl_off2", lcd_blon, 0);
        backlight = 1'b1;

        wait_ready("rstp");
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        @(negedge clk);
        k = cyc;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstp_en_before", lcd_en, 1);
        check("rstp_cyc", cyc - k, 3);
        reset = 1'b1;
        @(negedge clk);
        check("rstp_en", lcd_en, 0);
        check("rstp_done", init_done, 0);
        check("rstp_ready", req_ready, 0);
        reset = 1'b0;
        init_seq("reinit");

        check("rw_low", rw_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sequencer.md
# lcd_bus_sequencer

Sequences the HD44780-compatible 16x2 character LCD bus (8-bit DATA, EN, RS, RW, ON, BLON) on the DE2-class Nios II base system. Runs the power-on initialisation sequence itself, then accepts command/data byte writes from a single requester over a valid/ready handshake and generates setup, enable-pulse, hold and controller execution delays with cycle counters. Sits between the Avalon-facing LCD register logic and the top-level LCD pins; the top level owns the tri-state on DATA.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; documentation only, all delays are given in cycles
- SETUP_CYC, 4, RS/DATA valid before EN rises (>=40 ns)
- EN_CYC, 25, EN high width (>=450 ns)
- HOLD_CYC, 4, RS/DATA held after EN falls
- SHORT_CYC, 2_500, execution wait for normal commands and data (50 us)
- LONG_CYC, 100_000, execution wait for clear/home (2 ms)
- INIT_CYC, 1_000_000, power-on wait before the first command (20 ms)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  requester has a byte
- req_ready  out  1  sequencer accepts a byte this cycle
- req_rs  in  1  0 = instruction, 1 = data
- req_data  in  8  byte to write
- backlight  in  1  requested backlight state
- init_done  out  1  power-on sequence complete
- lcd_data  out  8  DATA pins (always driven; write-only)
- lcd_en  out  1  enable strobe
- lcd_rs  out  1  register select
- lcd_rw  out  1  always 0
- lcd_on  out  1  panel power
- lcd_blon  out  1  backlight

## Operation
- States: INIT_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, EXEC.
- INIT_WAIT: count INIT_CYC, then INIT_LOAD with init index 0.
- INIT_LOAD: load ROM[index] (0x38, 0x0C, 0x01, 0x06) with rs=0, index++, go SETUP. After EXEC of index 3, set init_done and go IDLE.
- IDLE: req_ready=1 iff init_done. On req_valid && req_ready, latch req_rs/req_data into lcd_rs/lcd_data, go SETUP.
- SETUP: lcd_en=0 for SETUP_CYC cycles -> PULSE: lcd_en=1 for EN_CYC cycles -> HOLD: lcd_en=0 for HOLD_CYC cycles -> EXEC: wait LONG_CYC if rs=0 and data[7:2]==0 (clear 0x01, home 0x02/0x03), else SHORT_CYC -> IDLE, or INIT_LOAD while !init_done.
- lcd_rs/lcd_data change only on acceptance or INIT_LOAD; held through SETUP..EXEC and in IDLE.
- req_ready=0 in every state except IDLE; req_valid during busy is ignored and not lost (requester holds it).
- lcd_blon = backlight registered, and 0 while !lcd_on.
- Counter: single down-counter, width $clog2(max of all *_CYC)+1; loaded with N-1 on state entry, state advances when it reads 0. Any *_CYC of 0 is treated as 1.

## Timing
- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=0, lcd_blon=0, req_ready=0, init_done=0, state INIT_WAIT.
- lcd_on goes 1 on the first edge after reset deasserts and stays 1.
- Acceptance at edge k: lcd_en rises at edge k+SETUP_CYC, falls at k+SETUP_CYC+EN_CYC; req_ready reasserts at edge k+SETUP_CYC+EN_CYC+HOLD_CYC+WAIT (WAIT = SHORT_CYC or LONG_CYC).
- Back-to-back: req_valid held high is accepted on the first IDLE cycle; no bubble beyond that one cycle.
- Reset asserted mid-transfer: lcd_en drops to 0 at that edge, init_done clears, full init sequence reruns.
- All outputs registered; no combinational path input->output except req_ready, which is decoded from state only.

## Structure
- Package lcd_seq_pkg: state enum, HD44780 constants (FUNC_SET_8BIT_2L=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06), init ROM, is_long_cmd(rs, data) function.
- One sub-module: lcd_delay_timer (load value, load strobe, done flag), instantiated once.

## Test plan
Bench parameters SETUP=2, EN=4, HOLD=2, SHORT=10, LONG=40, INIT=100.
- Release reset, idle requester -> lcd_on=1 next edge; four EN pulses with data 0x38, 0x0C, 0x01, 0x06, rs=0; gap after 0x01 is 40 cycles; init_done=1 at edge 100+4*8+3*10+40 plus state overheads, checked exactly.
- After init, write rs=1 data 0x41 -> EN high exactly 4 cycles starting 2 cycles after acceptance; rs=1, data=0x41 stable from acceptance through EXEC; req_ready back after 18 cycles.
- Write rs=0 data 0x02 -> 40-cycle EXEC; write rs=1 data 0x02 -> 10-cycle EXEC.
- req_valid held high with 3 bytes queued by bench -> each accepted on the first IDLE cycle, no drops, no double acceptance.
- Assert reset during PULSE of a data write -> lcd_en=0 at that edge, init_done=0, init sequence restarts with 0x38.
- Toggle backlight with lcd_on=1 -> lcd_blon follows one cycle later; lcd_rw remains 0 throughout all tests.
